// File: rtl/rd53_enum.sv
// rd53_enum: emits every 5-bit word of a requested Hamming weight, one per cycle, in numeric order.
module rd53_enum #(
  parameter bit ORDER_DESC = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  input  logic [2:0] req_weight,
  output logic       req_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_word,
  output logic       out_last,
  output logic [3:0] out_index,
  output logic       err,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;
  state_t state, state_nx;
  logic [2:0] k, k_nx, tz;
  logic [4:0] word_nx, first, last_word, x, c, ones, nxt, adv;
  logic [3:0] index_nx;
  logic [5:0] r;
  assign first = ORDER_DESC ? 5'h1f << (3'd5 - req_weight) : 5'h1f >> (3'd5 - req_weight);
  assign last_word = ORDER_DESC ? 5'h1f >> (3'd5 - k) : 5'h1f << (3'd5 - k);
  // Descending order is the ascending successor taken in the complemented domain.
  assign x = ORDER_DESC ? ~out_word : out_word;
  assign c = x & (~x + 5'd1);
  assign r = {1'b0, x} + {1'b0, c};
  assign tz = {c[4], c[2] | c[3], c[1] | c[3]};
  assign ones = 5'((({1'b0, x} ^ r) >> 2) >> tz);
  assign nxt = r[4:0] | ones;
  assign adv = ORDER_DESC ? ~nxt : nxt;
  assign req_ready = state == IDLE;
  assign out_valid = state == EMIT;
  assign err = state == ERR;
  assign busy = state != IDLE;
  assign out_last = out_valid && out_word == last_word;
  always_comb begin
    state_nx = state;
    k_nx = k;
    word_nx = out_word;
    index_nx = out_index;
    if (state == IDLE && req_valid) begin
      state_nx = req_weight > 3'd5 ? ERR : EMIT;
      k_nx = req_weight;
      word_nx = req_weight > 3'd5 ? out_word : first;
      index_nx = req_weight > 3'd5 ? out_index : 4'd0;
    end else if (state == EMIT && out_ready) begin
      state_nx = out_last ? IDLE : EMIT;
      word_nx = out_last ? out_word : adv;
      index_nx = out_last ? out_index : out_index + 4'd1;
    end else if (state == ERR) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= 3'd0;
      out_word <= 5'd0;
      out_index <= 4'd0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      out_word <= word_nx;
      out_index <= index_nx;
    end
  end
endmodule

// File: tb/tb_rd53_enum.sv
// tb_rd53_enum: scoreboard bench driving ascending and descending instances with shared stimulus.
module tb_rd53_enum;
  logic clk = 0, rst_n = 1, req_valid = 0, out_ready = 1;
  logic [2:0] req_weight = 0;
  logic req_ready[2], out_valid[2], out_last[2], err[2], busy[2];
  logic [4:0] out_word[2];
  logic [3:0] out_index[2];
  typedef struct packed {logic [4:0] word; logic last; logic [3:0] index;} exp_t;
  exp_t q0[$], q1[$];
  int checks = 0, errors = 0, err_seen = 0, err_exp = 0, mode = 0, cyc = 0, cur_k = 0;

  rd53_enum #(.ORDER_DESC(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_weight(req_weight),
    .req_ready(req_ready[0]), .out_valid(out_valid[0]), .out_ready(out_ready), .out_word(out_word[0]),
    .out_last(out_last[0]), .out_index(out_index[0]), .err(err[0]), .busy(busy[0]));
  rd53_enum #(.ORDER_DESC(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_weight(req_weight),
    .req_ready(req_ready[1]), .out_valid(out_valid[1]), .out_ready(out_ready), .out_word(out_word[1]),
    .out_last(out_last[1]), .out_index(out_index[1]), .err(err[1]), .busy(busy[1]));

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: every 5-bit value whose popcount is k, listed in plain numeric order.
  task automatic push_class(int k);
    logic [4:0] l[$];
    exp_t e;
    for (int w = 0; w < 32; w++) if ($countones(w) == k) l.push_back(5'(w));
    for (int i = 0; i < l.size(); i++) begin
      e.last = i == l.size() - 1;
      e.index = 4'(i);
      e.word = l[i];
      q0.push_back(e);
      e.word = l[l.size() - 1 - i];
      q1.push_back(e);
    end
  endtask

  always @(posedge clk) begin
    #2;
    cyc++;
    out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
  end

  logic pv[2], pr[2], pl[2], phs[2];
  logic [4:0] pw[2];
  logic [3:0] pi[2];
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        pv[d] = 0; pr[d] = 0; pl[d] = 0; phs[d] = 0;
      end else begin
        exp_t e;
        err_seen += int'(err[d]);
        if (phs[d] && !pl[d]) chk("no_bubble", int'(out_valid[d]), 1);
        if (phs[d] && pl[d]) chk("idle_after_last", {out_valid[d], req_ready[d]}, 2'b01);
        if (pv[d] && !pr[d]) chk("stall_hold", {out_valid[d], out_word[d], out_index[d]}, {1'b1, pw[d], pi[d]});
        if (out_valid[d] && out_ready) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            checks++; errors++;
            $display("FAIL sb_underflow dut%0d word=%b", d, out_word[d]);
          end else begin
            e = d == 0 ? q0.pop_front() : q1.pop_front();
            chk(d == 0 ? "asc_word_last_index" : "desc_word_last_index",
                {out_word[d], out_last[d], out_index[d]}, e);
            chk("popcount", $countones(out_word[d]), cur_k);
          end
        end
        pv[d] = out_valid[d]; pr[d] = out_ready; pl[d] = out_last[d];
        pw[d] = out_word[d]; pi[d] = out_index[d];
        phs[d] = out_valid[d] && out_ready;
      end
    end
  end

  task automatic send(int k);
    int t = 0;
    while (!req_ready[0] && t < 300) begin @(posedge clk); #2; t++; end
    chk("req_ready_wait", int'(req_ready[0]), 1);
    req_valid = 1; req_weight = 3'(k); cur_k = k;
    if (k <= 5) push_class(k); else err_exp++;
    @(posedge clk); #2;
    req_valid = 0;
    if (k <= 5) chk("first_latency", {out_valid[0], out_valid[1], req_ready[0], busy[0], err[0]}, 5'b11010);
    else begin
      chk("err_pulse", {err[0], err[1], out_valid[0], req_ready[0], busy[0]}, 5'b11001);
      @(posedge clk); #2;
      chk("err_clear", {err[0], err[1], req_ready[0], req_ready[1]}, 4'b0011);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (!(req_ready[0] && req_ready[1] && q0.size() == 0 && q1.size() == 0) && t < 500) begin
      @(posedge clk); #2; t++;
    end
    chk("drain", int'(t < 500), 1);
  endtask

  initial begin
    int t;
    #1 rst_n = 0;
    #1 chk("reset_state", {out_valid[0], out_valid[1], req_ready[0], req_ready[1], out_last[0], err[0], busy[0],
                            out_word[0], out_index[0]}, 16'b0011000_00000_0000);
    @(posedge clk); #2;
    rst_n = 1;
    mode = 0; send(2); wait_idle();
    send(0); send(5); wait_idle();
    chk("no_err_valid_k", err_seen, 0);
    send(6); send(7); wait_idle();
    mode = 1; send(3); wait_idle();
    mode = 0; send(3);
    t = 0;
    while (out_index[0] != 4'd4 && t < 50) begin @(posedge clk); #2; t++; end
    chk("reach_index4", int'(out_index[0]), 4);
    #1 rst_n = 0;
    #1 chk("rst_async", {out_valid[0], out_valid[1], req_ready[0], req_ready[1], busy[0], out_index[0], out_word[0]},
           {4'b0011, 1'b0, 4'd0, 5'd0});
    q0.delete(); q1.delete();
    @(posedge clk); #2;
    rst_n = 1;
    send(1); wait_idle();
    for (int k = 0; k <= 5; k++) send(k);
    wait_idle();
    mode = 2;
    repeat (25) send(int'($urandom_range(0, 7)));
    wait_idle();
    chk("err_count", err_seen, 2 * err_exp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rd53_enum.md
Name: rd53_enum

Overview:
- Inverse companion to the 5-input weight counter: accepts a 3-bit Hamming weight k and emits, one word per cycle, every 5-bit word whose popcount equals k.
- Used to drive exhaustive weight-class stimulus into rd53-style counters and for on-chip self-check of weight decoders.
- Valid/ready request side and valid/ready/last output stream.
- Words within a weight class are emitted in strict numeric order.

Parameters:
- ORDER_DESC, 0, 0 = ascending numeric order, 1 = descending numeric order; fixed at elaboration.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_weight  input  3  requested weight k, 0..7
- req_ready  output  1  block can accept a request
- out_valid  output  1  out_word is valid
- out_ready  input  1  consumer accepts out_word
- out_word  output  5  current word, bit i = input i of the counter
- out_last  output  1  out_word is the final word of the class
- out_index  output  4  0-based position of out_word within the class
- err  output  1  one-cycle pulse: request had k > 5
- busy  output  1  high while not IDLE

Behaviour:
- Reset (rst_n low, asynchronous) returns the block to IDLE.
  - req_ready = 1; out_valid, out_last, err and busy = 0.
  - out_word = 0 and out_index = 0.
  - Applies immediately, also mid-sequence; the partial sequence is discarded with no completion signalling.
- States: IDLE, EMIT, ERR.
- IDLE:
  - req_ready = 1.
  - On req_valid with k <= 5: go to EMIT; out_word loads the first word; out_index = 0; out_valid = 1 the next cycle. Request-to-first-word latency is 1 cycle.
  - First word, ascending: the k low bits set (k=3 gives 00111). Descending: the k high bits set (k=3 gives 11100).
  - On req_valid with k >= 6: go to ERR.
- ERR:
  - err = 1 and req_ready = 0 for exactly one cycle; no word is emitted; then return to IDLE.
- EMIT:
  - req_ready = 0; req_valid is ignored.
  - out_word, out_last and out_index are held stable while out_valid && !out_ready.
  - On a handshake (out_valid && out_ready) with out_last = 0: out_word advances to the next word of equal popcount, strictly greater (ascending) or smaller (descending); out_index increments.
  - On a handshake with out_last = 1: go to IDLE; out_valid drops the next cycle; req_ready = 1 the next cycle.
- Throughput: one word per cycle with out_ready held high; no bubbles between words.
- out_last is asserted combinationally from the current word: high when no further word of the same popcount exists in the chosen order.
  - Ascending: the last word is the k high bits set.
  - Descending: the last word is the k low bits set.
- Class sizes for k = 0..5: 1, 5, 10, 10, 5, 1. out_index on the last word is size-1.
- k = 0 emits the single word 00000 with out_last = 1. k = 5 emits the single word 11111 with out_last = 1.
- The next-word computation is purely combinational within one cycle (e.g. lowest-set-bit add and shift). Iterating over non-matching candidates is forbidden.
- All outputs are registered except out_last; out_last is a function of registered state only.

Test Plan:
- Reset, then req k=2, ORDER_DESC=0, out_ready=1 -> words 00011, 00101, 00110, 01001, 01010, 01100, 10001, 10010, 10100, 11000 on 10 consecutive cycles starting 1 cycle after the request; out_last only on 11000 (out_index 9); req_ready=1 the cycle after.
- k=0 then k=5 back-to-back -> single word 00000 with last, then single word 11111 with last; err never asserts.
- k=6 and k=7 -> err high exactly 1 cycle each, out_valid stays 0, req_ready low that cycle only.
- k=3 with out_ready toggled 1,0,0,1,... -> no word skipped or duplicated; word and index stable during stalls; all 10 words emitted.
- ORDER_DESC=1, k=1 -> 10000, 01000, 00100, 00010, 00001; last on 00001.
- rst_n pulsed low mid-sequence (k=3, index 4) -> out_valid=0 and req_ready=1 immediately; a new request k=1 restarts at index 0.
- Exhaustive: all k in 0..5, every emitted word fed into the weight counter reference model -> count equals k; word count per class equals C(5,k).
